// File: rtl/ahb_apb_bridge_pkg.sv
// Shared types and bus encodings for the AHB-Lite to APB3 bridge.
package ahb_apb_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_WDATA  = 3'd1,
    ST_SETUP  = 3'd2,
    ST_ACCESS = 3'd3,
    ST_ERR1   = 3'd4,
    ST_ERR2   = 3'd5
  } bridge_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

endpackage

// File: rtl/ahb_apb_bridge_if.sv
// AHB-Lite slave side and APB3 master side of the bridge in one bundle.
interface ahb_apb_bridge_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              hsel;
  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [DATA_W-1:0] hwdata;
  logic              hready;
  logic              hreadyout;
  logic              hresp;
  logic [DATA_W-1:0] hrdata;
  logic [ADDR_W-1:0] paddr;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready;
  logic              pslverr;
  logic              wr_err;

  modport slave (
    input  hsel, haddr, htrans, hwrite, hwdata, hready,
    output hreadyout, hresp, hrdata,
    output paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslverr,
    output wr_err
  );

  modport master (
    output hsel, haddr, htrans, hwrite, hwdata, hready,
    input  hreadyout, hresp, hrdata,
    input  paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslverr,
    input  wr_err
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite word transfers to APB3 SETUP/ACCESS, pslverr -> 2-cycle ERROR.
// Define AHB_APB_BRIDGE_POSTED_WR_EN for posted writes with wr_err pulses.
module ahb_apb_bridge
  import ahb_apb_bridge_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input logic             hclk,
  input logic             hreset,
  ahb_apb_bridge_if.slave bus
);

`ifdef AHB_APB_BRIDGE_POSTED_WR_EN
  localparam logic POSTED = 1'b1;
`else
  localparam logic POSTED = 1'b0;
`endif

  localparam logic [2:0] S_IDLE   = ST_IDLE;
  localparam logic [2:0] S_WDATA  = ST_WDATA;
  localparam logic [2:0] S_SETUP  = ST_SETUP;
  localparam logic [2:0] S_ACCESS = ST_ACCESS;
  localparam logic [2:0] S_ERR1   = ST_ERR1;
  localparam logic [2:0] S_ERR2   = ST_ERR2;

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic [ADDR_W-1:0] r_paddr;
  logic              r_pwrite;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_hrdata;
  logic              r_wr_err;
  logic              r_pnd;
  logic [ADDR_W-1:0] r_pnd_addr;
  logic              r_pnd_wr;

  logic              w_hready;
  logic              w_accept;
  logic              w_done;
  logic              w_err;
  logic [ADDR_W-1:0] w_addr;
  logic              w_unused;

  assign w_hready = (r_state == S_IDLE) |
                    (r_state == S_ERR2) |
                    (POSTED & (r_state == S_WDATA));
  assign w_accept = bus.hsel & bus.htrans[1] &
                    bus.hready & w_hready;
  assign w_done   = (r_state == S_ACCESS) & bus.pready;
  // posted write errors are reported on wr_err, not on hresp
  assign w_err    = w_done & bus.pslverr &
                    ~(POSTED & r_pwrite);
  assign w_addr   = {bus.haddr[ADDR_W-1:2], 2'b00};
  assign w_unused = ^{bus.haddr[1:0], bus.htrans[0]};

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_next = bus.hwrite ? S_WDATA : S_SETUP;
      end
      S_ERR2: begin
        if (w_accept)
          w_next = bus.hwrite ? S_WDATA : S_SETUP;
        else
          w_next = S_IDLE;
      end
      S_WDATA: w_next = S_SETUP;
      S_SETUP: w_next = S_ACCESS;
      S_ACCESS: begin
        if (bus.pready) begin
          if (w_err)
            w_next = S_ERR1;
          else if (r_pnd)
            w_next = r_pnd_wr ? S_WDATA : S_SETUP;
          else
            w_next = S_IDLE;
        end
      end
      S_ERR1:  w_next = S_ERR2;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_state    <= S_IDLE;
      r_paddr    <= '0;
      r_pwrite   <= 1'b0;
      r_pwdata   <= '0;
      r_hrdata   <= '0;
      r_wr_err   <= 1'b0;
      r_pnd      <= 1'b0;
      r_pnd_addr <= '0;
      r_pnd_wr   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && r_state != S_WDATA) begin
        r_paddr  <= w_addr;
        r_pwrite <= bus.hwrite;
      end
      // address phase arriving while a posted write is still pending
      if (w_accept && r_state == S_WDATA) begin
        r_pnd      <= 1'b1;
        r_pnd_addr <= w_addr;
        r_pnd_wr   <= bus.hwrite;
      end else if (w_done && r_pnd) begin
        r_pnd    <= 1'b0;
        r_paddr  <= r_pnd_addr;
        r_pwrite <= r_pnd_wr;
      end
      if (r_state == S_WDATA)
        r_pwdata <= bus.hwdata;
      if (w_done && !bus.pslverr && !r_pwrite)
        r_hrdata <= bus.prdata;
      r_wr_err <= POSTED & w_done &
                  bus.pslverr & r_pwrite;
    end
  end

  assign bus.hreadyout = w_hready;
  assign bus.hresp     = (r_state == S_ERR1 ||
                          r_state == S_ERR2) ?
                         HRESP_ERROR : HRESP_OKAY;
  assign bus.hrdata    = r_hrdata;
  assign bus.paddr     = r_paddr;
  assign bus.psel      = (r_state == S_SETUP) |
                         (r_state == S_ACCESS);
  assign bus.penable   = (r_state == S_ACCESS);
  assign bus.pwrite    = r_pwrite;
  assign bus.pwdata    = r_pwdata;
  assign bus.wr_err    = POSTED & r_wr_err;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Directed bench for ahb_apb_bridge with a small APB RAM/register slave.
module tb_ahb_apb_bridge;
  import ahb_apb_bridge_pkg::*;

  logic hclk = 1'b0;
  logic hreset;
  int   total = 0;
  int   bad   = 0;
  int   stall_cfg = 0;
  int   cnt;

  always #5 hclk = ~hclk;

  ahb_apb_bridge_if #(.ADDR_W(16), .DATA_W(32)) bus ();

  ahb_apb_bridge #(.ADDR_W(16), .DATA_W(32)) dut (
    .hclk   (hclk),
    .hreset (hreset),
    .bus    (bus)
  );

  // APB slave: RAM below 0x1000, reg at 0x1000, status at 0x1004
  logic [31:0] mem [0:1023];
  logic [31:0] reg0 = 32'h0;
  logic [3:0]  wcnt = 4'h0;

  assign bus.hready  = bus.hreadyout;
  assign bus.pready  = (wcnt == 4'h0) || !bus.penable;
  assign bus.pslverr = bus.psel && bus.penable &&
                       (bus.paddr >= 16'h1008);
  assign bus.prdata  = (bus.paddr < 16'h1000) ?
                       mem[bus.paddr[11:2]] :
                       (bus.paddr == 16'h1000) ? reg0 : 32'h0;

  always @(posedge hclk) begin
    if (bus.psel && !bus.penable)
      wcnt <= stall_cfg[3:0];
    else if (bus.psel && bus.penable && wcnt != 4'h0)
      wcnt <= wcnt - 4'h1;
    if (bus.psel && bus.penable && bus.pready &&
        bus.pwrite && !bus.pslverr) begin
      if (bus.paddr < 16'h1000)
        mem[bus.paddr[11:2]] <= bus.pwdata;
      else if (bus.paddr == 16'h1000)
        reg0 <= bus.pwdata;
    end
  end

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic addr_ph(input logic wr, input logic [15:0] a);
    bus.hsel   = 1'b1;
    bus.htrans = HTRANS_NONSEQ;
    bus.hwrite = wr;
    bus.haddr  = a;
  endtask

  task automatic idle_bus();
    bus.hsel   = 1'b0;
    bus.htrans = HTRANS_IDLE;
    bus.hwrite = 1'b0;
  endtask

  initial begin
    hreset     = 1'b1;
    bus.hwdata = 32'h0;
    bus.haddr  = 16'h0;
    idle_bus();
    repeat (3) tick();
    chk("rst_hreadyout", bus.hreadyout, 1);
    chk("rst_hresp", bus.hresp, 0);
    chk("rst_hrdata", bus.hrdata, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_psel", bus.psel, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    chk("rst_wr_err", bus.wr_err, 0);
    hreset = 1'b0;
    tick();

`ifndef AHB_APB_BRIDGE_POSTED_WR_EN
    // write 0x1000 <- 5, then read it back
    addr_ph(1'b1, 16'h1000);
    tick();
    idle_bus();
    bus.hwdata = 32'h5;
    chk("w1_wdata_hready", bus.hreadyout, 0);
    chk("w1_wdata_psel", bus.psel, 0);
    tick();
    chk("w1_setup_psel", bus.psel, 1);
    chk("w1_setup_pen", bus.penable, 0);
    chk("w1_setup_paddr", bus.paddr, 32'h1000);
    chk("w1_setup_pwrite", bus.pwrite, 1);
    chk("w1_setup_pwdata", bus.pwdata, 32'h5);
    chk("w1_setup_hready", bus.hreadyout, 0);
    tick();
    chk("w1_acc_pen", bus.penable, 1);
    chk("w1_acc_hready", bus.hreadyout, 0);
    tick();
    chk("w1_done_hready", bus.hreadyout, 1);
    chk("w1_done_psel", bus.psel, 0);
    chk("w1_done_hresp", bus.hresp, 0);
    addr_ph(1'b0, 16'h1000);
    tick();
    idle_bus();
    chk("r1_setup_hready", bus.hreadyout, 0);
    chk("r1_setup_pwrite", bus.pwrite, 0);
    tick();
    chk("r1_acc_pen", bus.penable, 1);
    tick();
    chk("r1_hready", bus.hreadyout, 1);
    chk("r1_hrdata", bus.hrdata, 32'h5);
    chk("r1_hresp", bus.hresp, 0);

    // RAM write then back-to-back read
    addr_ph(1'b1, 16'h0010);
    tick();
    idle_bus();
    bus.hwdata = 32'hDEADBEEF;
    repeat (3) tick();
    chk("w2_done_hready", bus.hreadyout, 1);
    addr_ph(1'b0, 16'h0010);
    tick();
    idle_bus();
    chk("r2_setup_psel", bus.psel, 1);
    chk("r2_setup_pen", bus.penable, 0);
    chk("r2_setup_paddr", bus.paddr, 32'h10);
    tick();
    tick();
    chk("r2_hready", bus.hreadyout, 1);
    chk("r2_hrdata", bus.hrdata, 32'hDEADBEEF);

    // status read with two pready=0 cycles
    stall_cfg = 2;
    addr_ph(1'b0, 16'h1004);
    tick();
    idle_bus();
    cnt = 0;
    for (int i = 0; i < 12 && bus.hreadyout == 1'b0; i++) begin
      cnt++;
      tick();
    end
    stall_cfg = 0;
    chk("r3_wait_cycles", cnt, 4);
    chk("r3_hrdata", bus.hrdata, 32'h0);

    // unmapped read -> pslverr -> ERR1/ERR2
    addr_ph(1'b0, 16'h2000);
    tick();
    idle_bus();
    chk("e_setup_hresp", bus.hresp, 0);
    tick();
    chk("e_acc_pen", bus.penable, 1);
    tick();
    chk("e_err1_hresp", bus.hresp, 1);
    chk("e_err1_hready", bus.hreadyout, 0);
    chk("e_err1_psel", bus.psel, 0);
    tick();
    chk("e_err2_hresp", bus.hresp, 1);
    chk("e_err2_hready", bus.hreadyout, 1);
    tick();
    chk("e_idle_hresp", bus.hresp, 0);
    chk("e_idle_hready", bus.hreadyout, 1);
    chk("e_wr_err", bus.wr_err, 0);
`else
    // posted write, then read held behind it
    addr_ph(1'b1, 16'h0020);
    tick();
    chk("pw_wdata_hready", bus.hreadyout, 1);
    chk("pw_wdata_hresp", bus.hresp, 0);
    bus.hwdata = 32'h12345678;
    addr_ph(1'b0, 16'h0020);
    tick();
    idle_bus();
    chk("pw_setup_psel", bus.psel, 1);
    chk("pw_setup_pwrite", bus.pwrite, 1);
    chk("pw_setup_pwdata", bus.pwdata, 32'h12345678);
    chk("pw_setup_paddr", bus.paddr, 32'h20);
    chk("pw_setup_hready", bus.hreadyout, 0);
    tick();
    chk("pw_acc_pen", bus.penable, 1);
    tick();
    chk("pr_setup_psel", bus.psel, 1);
    chk("pr_setup_pen", bus.penable, 0);
    chk("pr_setup_pwrite", bus.pwrite, 0);
    chk("pr_setup_hready", bus.hreadyout, 0);
    tick();
    tick();
    chk("pr_hready", bus.hreadyout, 1);
    chk("pr_hrdata", bus.hrdata, 32'h12345678);

    // posted write error -> single wr_err pulse
    addr_ph(1'b1, 16'h3000);
    tick();
    idle_bus();
    bus.hwdata = 32'hA5A5A5A5;
    tick();
    tick();
    chk("pe_acc_pen", bus.penable, 1);
    tick();
    chk("pe_wr_err", bus.wr_err, 1);
    chk("pe_hresp", bus.hresp, 0);
    chk("pe_hready", bus.hreadyout, 1);
    tick();
    chk("pe_wr_err_off", bus.wr_err, 0);
    chk("pe_hresp2", bus.hresp, 0);
`endif

    // reset in the middle of a stalled read
    stall_cfg = 3;
    addr_ph(1'b0, 16'h1000);
    tick();
    idle_bus();
    tick();
    chk("mr_acc_pen", bus.penable, 1);
    hreset = 1'b1;
    tick();
    chk("mr_psel", bus.psel, 0);
    chk("mr_penable", bus.penable, 0);
    chk("mr_hready", bus.hreadyout, 1);
    chk("mr_hresp", bus.hresp, 0);
    hreset    = 1'b0;
    stall_cfg = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge.md
# ahb_apb_bridge

Single-clock AHB-Lite slave to APB3 master bridge that sits directly upstream of the APB register/RAM slave (4 KB RAM at 0x0000–0x0FFF, registers at 0x1000/0x1004). It converts each non-sequential or sequential AHB word transfer into one APB SETUP/ACCESS transaction. It inserts AHB wait states until the APB side completes, and maps `pslverr` onto a two-cycle AHB ERROR response.

## Interface
- `ADDR_W`, 16: address width carried to APB.
- `DATA_W`, 32: data width; only 32 is supported.
- `hclk` in 1: single clock for both the AHB and APB sides (`pclk` = `hclk`).
- `hreset` in 1: reset, synchronous, active-high.
- `hsel` in 1: slave select.
- `haddr` in ADDR_W: AHB address.
- `htrans` in 2: transfer type; bit 1 set means NONSEQ/SEQ.
- `hwrite` in 1: 1 = write.
- `hwdata` in DATA_W: write data, valid in the data phase.
- `hready` in 1: bus-level ready; an address phase is accepted only when high.
- `hreadyout` out 1: bridge ready.
- `hresp` out 1: 0 = OKAY, 1 = ERROR.
- `hrdata` out DATA_W: read data.
- `paddr` out ADDR_W: APB address, with [1:0] forced to 0.
- `psel` out 1: APB select.
- `penable` out 1: APB enable.
- `pwrite` out 1: APB direction.
- `pwdata` out DATA_W: APB write data.
- `prdata` in DATA_W: APB read data.
- `pready` in 1: APB ready.
- `pslverr` in 1: APB error.
- `wr_err` out 1: one-cycle pulse on a posted-write error (posted build only, otherwise tied 0).

## Operation
- **Accept condition:** `hsel & htrans[1] & hready & hreadyout` at a rising edge. On accept, latch `haddr`, `hwrite`.
- **Ignored transfers:** IDLE/BUSY or unselected transfers get a zero-wait OKAY.
- **States:** IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- **IDLE:**
  - accepted read → SETUP.
  - accepted write → WDATA.
- **WDATA:** capture `hwdata` into `pwdata` → SETUP.
- **SETUP:** `psel`=1, `penable`=0 → ACCESS.
- **ACCESS:** `psel`=1, `penable`=1; hold while `pready`=0. When `pready`=1:
  - `pslverr`=0: capture `prdata` into `hrdata` for reads → IDLE.
  - `pslverr`=1 → ERR1.
- **ERR1:** `hresp`=1, `hreadyout`=0 → ERR2.
- **ERR2:** `hresp`=1, `hreadyout`=1 → IDLE. Any address phase accepted in ERR2 is processed normally.
- **hreadyout:** 0 in WDATA, SETUP, ACCESS and ERR1; 1 in IDLE and ERR2.
- **Outputs outside SETUP/ACCESS:** `paddr`/`pwrite` hold their last values; `psel`=`penable`=0.
- **Reset values:** `hreadyout`=1, `hresp`=0, `hrdata`=0, `paddr`=0, `psel`=0, `penable`=0, `pwrite`=0, `pwdata`=0, `wr_err`=0; state=IDLE.
- **Reset mid-transfer:** `psel`/`penable` drop at the reset edge. The in-flight transfer is discarded and no AHB response is completed.
- **hsize:** ignored; every transfer is treated as a 32-bit word.

## Timing
Address phase in cycle T.
- **Read:**
  - SETUP at T+1, ACCESS at T+2 (with `pready`=1).
  - `hreadyout`=0 in T+1 and T+2; `hrdata` valid with `hreadyout`=1 in T+3.
  - Two wait states minimum, plus one per APB `pready`=0 cycle.
- **Write (non-posted):**
  - WDATA at T+1, SETUP at T+2, ACCESS at T+3.
  - `hreadyout`=1 in T+4; three wait states minimum.
- **Back-to-back:** the next address phase is accepted in the cycle where `hreadyout` returns to 1, and its SETUP/WDATA follows on the next cycle. There is no idle APB cycle between transfers beyond that.
- **Error:** ACCESS ending with `pslverr` adds ERR1 then ERR2 (two cycles of `hresp`=1).

## Configuration
- **`AHB_APB_BRIDGE_POSTED_WR_EN` defined:** writes are posted.
  - `hreadyout` stays 1 in WDATA; the AHB write completes OKAY at T+1.
  - `hwdata` is captured at the end of T+1, and the APB write runs T+2/T+3.
  - A new address phase accepted during WDATA is held. Its data phase stalls (`hreadyout`=0) until the posted APB write finishes, then it proceeds from IDLE rules.
  - A `pslverr` on a posted write does not enter ERR1/ERR2; it pulses `wr_err` for one cycle instead.
- **Undefined:** non-posted behaviour as above, with `wr_err` tied 0.

## Structure
- **Package `ahb_apb_bridge_pkg`:**
  - bridge state enum;
  - HTRANS encodings (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3);
  - HRESP constants (OKAY, ERROR).
- **Sub-module:** none. The FSM and pipeline registers fit in a single module.

## Test plan
- Reset with `hreset`=1 for 3 cycles → all outputs at their reset values, `hreadyout`=1.
- Write 0x1000 ← 0x0000_0005, then read 0x1000 → APB write at SETUP T+2/ACCESS T+3. Read returns `hrdata`=0x0000_0005 at T+3, OKAY.
- Write RAM 0x0010 ← 0xDEAD_BEEF, then immediate back-to-back read 0x0010 → 0xDEAD_BEEF. No gap beyond the specified wait states.
- Read 0x1004 with `pready` held 0 for 2 extra ACCESS cycles → `hreadyout` low for 4 cycles. `hrdata`=0 (status reset value).
- `pslverr`=1 on read of 0x2000 → ERR1 (`hresp`=1, `hreadyout`=0), then ERR2 (`hresp`=1, `hreadyout`=1), then OKAY idle.
- With `AHB_APB_BRIDGE_POSTED_WR_EN`: write 0x0020 ← 0x1234_5678 → `hreadyout`=1 at T+1. A following read of 0x0020 stalls until the write finishes, then returns 0x1234_5678. Injected `pslverr` on a posted write gives a single `wr_err` pulse and no `hresp`.
